// File: rtl/memory_map_pkg.sv
// Address map, transmitter state encoding and register bit positions shared by
// the data-side memory responder and its UART transmitter.
package memory_map_pkg;

  localparam logic [31:0] MMIO_BASE   = 32'h8000_0000;
  localparam logic [31:0] UART_ADDR   = 32'h8000_0000;
  localparam logic [31:0] CNT_LO_ADDR = 32'h8000_0004;
  localparam logic [31:0] CNT_HI_ADDR = 32'h8000_0008;
  localparam logic [31:0] FAULT_ADDR  = 32'h8000_000C;

  typedef logic [1:0] tx_state_t;
  localparam tx_state_t TX_IDLE  = 2'd0;
  localparam tx_state_t TX_START = 2'd1;
  localparam tx_state_t TX_DATA  = 2'd2;
  localparam tx_state_t TX_STOP  = 2'd3;

  localparam int STATUS_FULL_BIT    = 0;
  localparam int STATUS_EMPTY_BIT   = 1;
  localparam int STATUS_BUSY_BIT    = 2;
  localparam int FAULT_OVERFLOW_BIT = 8;

  localparam logic [7:0] FAULT_COUNT_MAX = 8'hFF;

  typedef enum logic [2:0] {
    REGION_RAM,
    REGION_UART,
    REGION_CNT_LO,
    REGION_CNT_HI,
    REGION_FAULT,
    REGION_UNMAPPED
  } region_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == FAULT_COUNT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/uart_transmitter.sv
// Buffered 8N1 UART transmitter: a small push-only FIFO feeding a
// start/data/stop state machine that drains it with no gap between frames.
module uart_transmitter
  import memory_map_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       uart_tx
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]    PTR_ONE   = (PTR_W + 1)'(1);

  logic [7:0]        fifo_q [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  tx_state_t         state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic              tx_q, tx_d;
  logic              push_ok;
  logic              pop;
  logic              baud_done;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push_ok   = push && !full;
  assign busy      = (state_q != TX_IDLE);
  assign baud_done = (baud_q == BAUD_LAST);
  assign uart_tx   = tx_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    pop       = 1'b0;

    case (state_q)
      TX_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (baud_done) state_d = TX_DATA;
      end
      TX_DATA: begin
        if (baud_done) begin
          if (bit_idx_q == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (baud_done) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    if (pop) begin
      shift_d   = fifo_q[rd_ptr_q[PTR_W-1:0]];
      bit_idx_d = 3'd0;
    end

    baud_d = (baud_done || state_q == TX_IDLE) ? '0 : baud_q + BAUD_W'(1);

    // The line level is registered from the next state so uart_tx is glitch-free.
    case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase

    wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= TX_IDLE;
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
      baud_q    <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      baud_q    <= baud_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // NOTE: storage arrays are not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/data_memory.sv
// Data-port responder for the RV32I core: byte-lane RAM with a combinational
// read path plus the bring-up MMIO block (UART, cycle counter, fault register).
module data_memory
  import memory_map_pkg::*;
#(
  parameter int RAM_WORDS    = 1024,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_write_value,
  input  logic [2:0]  memory_write_sections,
  output logic [31:0] memory_read_value,
  output logic        uart_tx
);

  localparam int          RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [32:0] RAM_LIMIT = 33'(RAM_WORDS) << 2;

  logic [31:0]       mem_q [RAM_WORDS];
  logic [63:0]       cnt_q, cnt_d;
  logic [7:0]        fault_cnt_q, fault_cnt_d;
  logic              overflow_q, overflow_d;

  logic [1:0]        byte_off;
  logic              is_write;
  logic [6:0]        lane_wide;
  logic [3:0]        lane_mask;
  logic              lane_overflow;
  logic [31:0]       write_data;
  logic [RAM_AW-1:0] ram_index;
  logic [31:0]       ram_word;
  region_t           region;

  logic              ram_we;
  logic              uart_push;
  logic              fault_clear;
  logic              fault_event;
  logic              uart_full;
  logic              uart_empty;
  logic              uart_busy;
  logic [31:0]       status_word;
  logic [31:0]       fault_word;

  assign byte_off      = memory_address[1:0];
  assign is_write      = |memory_write_sections;
  assign lane_wide     = {3'b000, memory_write_sections[2], memory_write_sections[2],
                          memory_write_sections[1], memory_write_sections[0]} << byte_off;
  assign lane_mask     = lane_wide[3:0];
  // A mask bit pushed past byte 3 would spill into the next word.
  assign lane_overflow = |lane_wide[6:4];
  assign write_data    = memory_write_value << {byte_off, 3'b000};
  assign ram_index     = memory_address[RAM_AW+1:2];
  assign ram_word      = mem_q[ram_index];

  // Misaligned MMIO accesses decode as unmapped: read 0, writes dropped and counted.
  always_comb begin
    region = REGION_UNMAPPED;
    if ({1'b0, memory_address} < RAM_LIMIT) begin
      region = REGION_RAM;
    end else if (memory_address[31:8] == MMIO_BASE[31:8] && byte_off == 2'b00) begin
      if      (memory_address == UART_ADDR)   region = REGION_UART;
      else if (memory_address == CNT_LO_ADDR) region = REGION_CNT_LO;
      else if (memory_address == CNT_HI_ADDR) region = REGION_CNT_HI;
      else if (memory_address == FAULT_ADDR)  region = REGION_FAULT;
      else                                    region = REGION_UNMAPPED;
    end
  end

  always_comb begin
    ram_we      = 1'b0;
    uart_push   = 1'b0;
    fault_clear = 1'b0;
    fault_event = 1'b0;
    if (is_write) begin
      case (region)
        REGION_RAM: begin
          if (lane_overflow) fault_event = 1'b1;
          else               ram_we      = 1'b1;
        end
        REGION_UART:   uart_push   = 1'b1;
        REGION_FAULT:  fault_clear = 1'b1;
        REGION_CNT_LO: ;
        REGION_CNT_HI: ;
        default:       fault_event = 1'b1;
      endcase
    end
  end

  always_comb begin
    status_word                   = '0;
    status_word[STATUS_FULL_BIT]  = uart_full;
    status_word[STATUS_EMPTY_BIT] = uart_empty;
    status_word[STATUS_BUSY_BIT]  = uart_busy;

    fault_word                     = '0;
    fault_word[7:0]                = fault_cnt_q;
    fault_word[FAULT_OVERFLOW_BIT] = overflow_q;

    case (region)
      REGION_RAM:    memory_read_value = ram_word >> {byte_off, 3'b000};
      REGION_UART:   memory_read_value = status_word;
      REGION_CNT_LO: memory_read_value = cnt_q[31:0];
      REGION_CNT_HI: memory_read_value = cnt_q[63:32];
      REGION_FAULT:  memory_read_value = fault_word;
      default:       memory_read_value = '0;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q + 64'd1;
    fault_cnt_d = fault_cnt_q;
    overflow_d  = overflow_q;
    if (fault_clear) begin
      fault_cnt_d = 8'h00;
      overflow_d  = 1'b0;
    end else begin
      if (fault_event) fault_cnt_d = sat_inc(fault_cnt_q);
      // Fullness is judged before the edge, so a pop on the same edge does not save the byte.
      if (uart_push && uart_full) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= 64'd0;
      fault_cnt_q <= 8'h00;
      overflow_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      fault_cnt_q <= fault_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_mask[b]) mem_q[ram_index][8*b +: 8] <= write_data[8*b +: 8];
      end
    end
  end

  uart_transmitter #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_transmitter (
    .clk      (clk),
    .reset    (reset),
    .push     (uart_push),
    .push_data(memory_write_value[7:0]),
    .full     (uart_full),
    .empty    (uart_empty),
    .busy     (uart_busy),
    .uart_tx  (uart_tx)
  );

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: drivers queue expected read values and
// UART frames; independent monitors pop and compare when output is presented.
module tb_data_memory;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int WORDS = 1024;

  localparam logic [31:0] A_UART  = 32'h8000_0000;
  localparam logic [31:0] A_CLO   = 32'h8000_0004;
  localparam logic [31:0] A_CHI   = 32'h8000_0008;
  localparam logic [31:0] A_FAULT = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] memory_address = '0;
  logic [31:0] memory_write_value = '0;
  logic [2:0]  memory_write_sections = '0;
  logic [31:0] memory_read_value;
  logic        uart_tx;

  data_memory #(
    .RAM_WORDS   (WORDS),
    .FIFO_DEPTH  (DEPTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .memory_address       (memory_address),
    .memory_write_value   (memory_write_value),
    .memory_write_sections(memory_write_sections),
    .memory_read_value    (memory_read_value),
    .uart_tx              (uart_tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        rd_valid = 1'b0;
  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic [7:0]  tx_exp_q[$];
  int          tx_start_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- drivers: one task call = one clock cycle ----------------
  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s,
                       input logic v);
    @(posedge clk);
    #1;
    memory_address        = a;
    memory_write_value    = d;
    memory_write_sections = s;
    rd_valid              = v;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
    drive(a, d, s, 1'b0);
  endtask

  task automatic do_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    drive(a, 32'h0, 3'b000, 1'b1);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(32'h0, 32'h0, 3'b000, 1'b0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset                 = 1'b0;
    rd_valid              = 1'b0;
    memory_write_sections = 3'b000;
  endtask

  // ---------------- read monitor ----------------
  string       mon_name;
  logic [31:0] mon_exp;
  initial begin
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        if (rd_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_scoreboard: read presented at cycle %0d with no expectation", cyc);
        end else begin
          mon_exp  = rd_exp_q.pop_front();
          mon_name = rd_name_q.pop_front();
          check(mon_name, memory_read_value, mon_exp);
        end
      end
    end
  end

  // ---------------- UART monitor: samples every cycle of a 10*CPB frame ----------------
  logic       samples [10*CPB];
  int         frame_start;
  int         s_idx;
  logic       aborted;
  logic       shape_ok;
  logic [7:0] rx_byte;
  logic [7:0] exp_byte;
  int         exp_start;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && uart_tx === 1'b0) begin
        frame_start = cyc;
        samples[0]  = uart_tx;
        aborted     = 1'b0;
        s_idx       = 1;
        while (s_idx < 10*CPB && !aborted) begin
          @(negedge clk);
          if (reset) aborted = 1'b1;
          samples[s_idx] = uart_tx;
          s_idx++;
        end
        if (!aborted) begin
          shape_ok = 1'b1;
          for (int b = 0; b < 10; b++)
            for (int j = 0; j < CPB; j++)
              if (samples[CPB*b+j] !== samples[CPB*b]) shape_ok = 1'b0;
          if (samples[9*CPB] !== 1'b1) shape_ok = 1'b0;
          for (int i = 0; i < 8; i++) rx_byte[i] = samples[CPB*(i+1)];
          if (tx_exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_scoreboard: unexpected frame 0x%02h at cycle %0d", rx_byte, frame_start);
          end else begin
            exp_byte  = tx_exp_q.pop_front();
            exp_start = tx_start_q.pop_front();
            check("tx_data", {24'h0, rx_byte}, {24'h0, exp_byte});
            check("tx_frame_shape", {31'h0, shape_ok}, 32'h1);
            check("tx_start_cycle", 32'(frame_start), 32'(exp_start));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $fatal(1, "simulation time limit reached");
  end

  // ---------------- stimulus ----------------
  logic [7:0] burst [6];
  int         s0;
  initial begin
    burst[0] = 8'h3C; burst[1] = 8'hC3; burst[2] = 8'h5A;
    burst[3] = 8'h0F; burst[4] = 8'hF0; burst[5] = 8'h99;

    #1 reset = 1'b1;
    do_read("status_in_reset", A_UART, 32'h2);
    do_read("fault_in_reset", A_FAULT, 32'h0);
    do_read("cnt_lo_in_reset", A_CLO, 32'h0);
    check("tx_idle_in_reset", {31'h0, uart_tx}, 32'h1);
    release_reset();
    idle(99);
    do_read("cnt_lo_after_100", A_CLO, 32'd100);
    do_read("cnt_hi_zero", A_CHI, 32'h0);

    // byte-lane writes
    do_write(32'h100, 32'h1122_3344, 3'b111);
    do_write(32'h102, 32'h0000_00AA, 3'b001);
    do_write(32'h100, 32'h0000_BEEF, 3'b011);
    do_read("lane_word", 32'h100, 32'h11AA_BEEF);
    do_read("lane_byte3", 32'h103, 32'h0000_0011);
    do_read("lane_off2", 32'h102, 32'h0000_11AA);

    // misaligned writes
    do_write(32'h101, 32'hDEAD_BEEF, 3'b111);
    do_write(32'h103, 32'h0000_1234, 3'b011);
    do_read("misaligned_ram_kept", 32'h100, 32'h11AA_BEEF);
    do_read("fault_two", A_FAULT, 32'h002);
    do_write(32'h103, 32'h0000_0077, 3'b001);
    do_read("sb_top_byte", 32'h100, 32'h77AA_BEEF);
    do_read("fault_still_two", A_FAULT, 32'h002);
    do_write(A_FAULT, 32'h0, 3'b111);
    do_read("fault_cleared", A_FAULT, 32'h0);

    // unmapped and boundary accesses
    do_read("unmapped_read", 32'h4000_0000, 32'h0);
    do_write(32'h4000_0000, 32'h55, 3'b111);
    do_read("unmapped_write_fault", A_FAULT, 32'h001);
    do_write(32'h0000_0FFC, 32'hCAFE_F00D, 3'b111);
    do_read("ram_last_word", 32'h0000_0FFC, 32'hCAFE_F00D);
    do_read("ram_end_unmapped", 32'h0000_1000, 32'h0);
    do_write(32'h0000_1000, 32'h1, 3'b111);
    do_write(32'h8000_0001, 32'h41, 3'b001);
    do_write(A_CLO, 32'h5, 3'b111);
    do_read("mmio_misaligned_read", 32'h8000_0005, 32'h0);
    do_read("fault_three", A_FAULT, 32'h003);
    do_read("status_idle", A_UART, 32'h2);
    do_write(A_FAULT, 32'h0, 3'b111);

    // single frame 0xA5
    do_write(A_UART, 32'h0000_00A5, 3'b001);
    tx_exp_q.push_back(8'hA5);
    tx_start_q.push_back(cyc + 2);
    do_read("status_pending", A_UART, 32'h0);
    do_read("status_busy", A_UART, 32'h6);
    idle(45);
    do_read("status_after_frame", A_UART, 32'h2);

    // six back-to-back writes into a 4-deep FIFO
    s0 = 0;
    for (int i = 0; i < 6; i++) begin
      do_write(A_UART, {24'h0, burst[i]}, 3'b001);
      if (i == 0) s0 = cyc + 2;
      if (i < 5) begin
        tx_exp_q.push_back(burst[i]);
        tx_start_q.push_back(s0 + 10*CPB*i);
      end
    end
    do_read("status_full_busy", A_UART, 32'h5);
    do_read("fault_overflow", A_FAULT, 32'h100);
    idle(210);
    do_read("status_drained", A_UART, 32'h2);

    // fault count saturation
    repeat (260) do_write(32'h102, 32'hFFFF_FFFF, 3'b111);
    do_read("fault_saturated", A_FAULT, 32'h1FF);
    do_read("ram_after_saturation", 32'h100, 32'h77AA_BEEF);
    do_write(A_FAULT, 32'h0, 3'b111);
    do_read("fault_cleared_again", A_FAULT, 32'h0);

    // reset in the middle of a frame of 0x00
    do_write(A_UART, 32'h0, 3'b001);
    idle(12);
    check("tx_low_mid_frame", {31'h0, uart_tx}, 32'h0);
    reset = 1'b1;
    #1;
    check("tx_high_on_reset", {31'h0, uart_tx}, 32'h1);
    do_read("status_reset_mid_frame", A_UART, 32'h2);
    release_reset();
    do_read("status_after_release", A_UART, 32'h2);
    idle(60);

    for (int i = 0; i < 500 && tx_exp_q.size() != 0; i++) @(posedge clk);
    check("tx_queue_drained", 32'(tx_exp_q.size()), 32'h0);
    check("rd_queue_drained", 32'(rd_exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
